// File: rtl/apb_master_ctrl_if.sv
// Bundle of command-FIFO, read-data-FIFO, APB and status signals around
// the APB master sequencer. master = sequencer side, slave = environment.
interface apb_master_ctrl_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CW = 16
);
    // command FIFO (first-word-fall-through head)
    logic          cmd_empty;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          cmd_write;
    logic          cmd_rd_en;

    // read-data FIFO
    logic          rd_full;
    logic          rd_wr_en;
    logic [DW-1:0] rd_wdata;

    // APB
    logic          Psel;
    logic          Penable;
    logic          Pwrite;
    logic [AW-1:0] Paddr;
    logic [DW-1:0] Pdata;
    logic [DW-1:0] Prdata;
    logic          Pready;
    logic          Pslverr;

    // status
    logic          busy;
    logic          err_pulse;
    logic          timeout_pulse;
    logic [CW-1:0] xfer_cnt;

    modport master (
        input  cmd_empty, cmd_addr, cmd_wdata, cmd_write,
        input  rd_full,
        input  Prdata, Pready, Pslverr,
        output cmd_rd_en, rd_wr_en, rd_wdata,
        output Psel, Penable, Pwrite, Paddr, Pdata,
        output busy, err_pulse, timeout_pulse, xfer_cnt
    );

    modport slave (
        output cmd_empty, cmd_addr, cmd_wdata, cmd_write,
        output rd_full,
        output Prdata, Pready, Pslverr,
        input  cmd_rd_en, rd_wr_en, rd_wdata,
        input  Psel, Penable, Pwrite, Paddr, Pdata,
        input  busy, err_pulse, timeout_pulse, xfer_cnt
    );
endinterface

// File: rtl/apb_master_ctrl.sv
// APB side of the AHB-to-APB bridge: pops commands from the command FIFO,
// runs the APB SETUP/ACCESS phases, waits on Pready with an optional
// timeout, and pushes read results into the read-data FIFO.
module apb_master_ctrl #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16,
    parameter int CW      = 16
) (
    input  logic                Pclk,
    input  logic                Preset,
    apb_master_ctrl_if.master   bus
);

    // Wait counter only needs to reach TIMEOUT-1.
    localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = (TIMEOUT > 0) ? WCW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           psel_q, psel_d;
    logic           penable_q, penable_d;
    logic           pwrite_q, pwrite_d;
    logic [AW-1:0]  paddr_q, paddr_d;
    logic [DW-1:0]  pdata_q, pdata_d;
    logic [WCW-1:0] wait_q, wait_d;
    logic           err_q, err_d;
    logic           to_q, to_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           cmd_rd_en_c;
    logic           rd_wr_en_c;
    logic [DW-1:0]  rd_wdata_c;
    logic           start;
    logic           timeout_hit;

    // A read may only start when the read-data FIFO has room for its result.
    assign start       = !bus.cmd_empty && (bus.cmd_write || !bus.rd_full);
    assign timeout_hit = (TIMEOUT > 0) && (wait_q == WAIT_LAST);

    // Next-state, datapath and combinational FIFO handshakes.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pdata_d     = pdata_q;
        wait_d      = wait_q;
        err_d       = 1'b0;
        to_d        = 1'b0;
        cnt_d       = cnt_q;
        cmd_rd_en_c = 1'b0;
        rd_wr_en_c  = 1'b0;
        rd_wdata_c  = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cmd_rd_en_c = 1'b1;
                    paddr_d     = bus.cmd_addr;
                    pdata_d     = bus.cmd_wdata;
                    pwrite_d    = bus.cmd_write;
                    psel_d      = 1'b1;
                    state_d     = S_SETUP;
                end
            end
            S_SETUP: begin
                penable_d = 1'b1;
                wait_d    = '0;
                state_d   = S_ACCESS;
            end
            S_ACCESS: begin
                if (bus.Pready) begin
                    rd_wr_en_c = !pwrite_q;
                    rd_wdata_c = bus.Prdata;
                    err_d      = bus.Pslverr;
                    cnt_d      = cnt_q + 1'b1;
                    psel_d     = 1'b0;
                    penable_d  = 1'b0;
                    state_d    = S_IDLE;
                end else if (timeout_hit) begin
                    // Aborted reads still push a (zero) word so responses
                    // stay 1:1 with read commands.
                    rd_wr_en_c = !pwrite_q;
                    rd_wdata_c = '0;
                    err_d      = 1'b1;
                    to_d       = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                    psel_d     = 1'b0;
                    penable_d  = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase

        // No FIFO traffic while reset is held, even mid-transfer.
        if (Preset) begin
            cmd_rd_en_c = 1'b0;
            rd_wr_en_c  = 1'b0;
            rd_wdata_c  = '0;
        end
    end

    // State and registered APB/status outputs, synchronous reset.
    always_ff @(posedge Pclk) begin
        if (Preset) begin
            state_q   <= S_IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pdata_q   <= '0;
            wait_q    <= '0;
            err_q     <= 1'b0;
            to_q      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pdata_q   <= pdata_d;
            wait_q    <= wait_d;
            err_q     <= err_d;
            to_q      <= to_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.cmd_rd_en     = cmd_rd_en_c;
    assign bus.rd_wr_en      = rd_wr_en_c;
    assign bus.rd_wdata      = rd_wdata_c;
    assign bus.Psel          = psel_q;
    assign bus.Penable       = penable_q;
    assign bus.Pwrite        = pwrite_q;
    assign bus.Paddr         = paddr_q;
    assign bus.Pdata         = pdata_q;
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.err_pulse     = err_q;
    assign bus.timeout_pulse = to_q;
    assign bus.xfer_cnt      = cnt_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl (TIMEOUT=4): a small command queue
// feeds the DUT, a scripted APB slave answers, per-cycle events are logged
// and each scenario task checks them against hand-derived values.
module tb_apb_master_ctrl;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
    } cmd_t;

    logic clk;
    logic rst;

    apb_master_ctrl_if #(.AW(32), .DW(32), .CW(16)) bus ();

    apb_master_ctrl #(.AW(32), .DW(32), .TIMEOUT(4), .CW(16)) dut (
        .Pclk   (clk),
        .Preset (rst),
        .bus    (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cmd_t q[$];
    int checks = 0;
    int errors = 0;

    // slave script
    int          waits;       // Pready low cycles per transfer, -1 = never ready
    int          acc_n;
    logic        slverr_cfg;
    logic [31:0] prdata_cfg;

    // event log
    int cyc, n_pop, n_push, n_psel, n_pen, n_err, n_to;
    int first_pop, first_psel, first_pen, last_pen, push_cyc, err_cyc, to_cyc;
    int pop_cyc[8];
    logic [31:0] push_data, cap_addr, cap_data;
    logic        cap_write;

    task automatic drive_head();
        if (q.size() == 0) begin
            bus.cmd_empty = 1'b1;
            bus.cmd_addr  = '0;
            bus.cmd_wdata = '0;
            bus.cmd_write = 1'b0;
        end else begin
            bus.cmd_empty = 1'b0;
            bus.cmd_addr  = q[0].addr;
            bus.cmd_wdata = q[0].wdata;
            bus.cmd_write = q[0].write;
        end
    endtask

    task automatic push_cmd(input logic [31:0] a, input logic [31:0] d, input logic w);
        cmd_t c;
        c.addr = a; c.wdata = d; c.write = w;
        q.push_back(c);
        drive_head();
    endtask

    task automatic clear_log();
        cyc = 0; n_pop = 0; n_push = 0; n_psel = 0; n_pen = 0; n_err = 0; n_to = 0;
        first_pop = -1; first_psel = -1; first_pen = -1; last_pen = -1;
        push_cyc = -1; err_cyc = -1; to_cyc = -1;
        push_data = 'x; cap_addr = 'x; cap_data = 'x; cap_write = 1'bx;
        for (int i = 0; i < 8; i++) pop_cyc[i] = -1;
    endtask

    // One clock: drive slave, log this cycle's outputs, cross the edge,
    // pop the queue if the DUT popped, land just after the next negedge.
    task automatic cycle();
        logic pop;
        if (bus.Psel && bus.Penable) begin
            bus.Pready  = (waits >= 0) && (acc_n >= waits);
            bus.Pslverr = slverr_cfg && bus.Pready;
            bus.Prdata  = prdata_cfg;
        end else begin
            bus.Pready  = 1'b0;
            bus.Pslverr = 1'b0;
            bus.Prdata  = '0;
        end
        #1;
        if (bus.cmd_rd_en) begin
            if (n_pop < 8) pop_cyc[n_pop] = cyc;
            if (first_pop < 0) first_pop = cyc;
            n_pop++;
        end
        if (bus.rd_wr_en) begin n_push++; push_data = bus.rd_wdata; push_cyc = cyc; end
        if (bus.Psel) begin n_psel++; if (first_psel < 0) first_psel = cyc; end
        if (bus.Penable) begin
            n_pen++; last_pen = cyc;
            if (first_pen < 0) first_pen = cyc;
            cap_addr = bus.Paddr; cap_data = bus.Pdata; cap_write = bus.Pwrite;
        end
        if (bus.err_pulse) begin n_err++; if (err_cyc < 0) err_cyc = cyc; end
        if (bus.timeout_pulse) begin n_to++; if (to_cyc < 0) to_cyc = cyc; end
        pop = bus.cmd_rd_en;
        if (bus.Psel && bus.Penable) acc_n++; else acc_n = 0;
        @(posedge clk);
        if (pop && q.size() > 0) void'(q.pop_front());
        @(negedge clk);
        drive_head();
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        push_cmd(32'h10, 32'hA5A5_A5A5, 1'b1);
        clear_log();
        repeat (3) cycle();
        checks++; if (n_pop !== 0) begin errors++; $display("FAIL reset_no_pop got %0d want 0", n_pop); end
        checks++; if (bus.cmd_rd_en !== 1'b0) begin errors++; $display("FAIL reset_cmd_rd_en got %b want 0", bus.cmd_rd_en); end
        checks++;
        if ({bus.Psel, bus.Penable, bus.Pwrite, bus.rd_wr_en, bus.busy, bus.err_pulse, bus.timeout_pulse} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b%b%b%b%b%b%b want 0000000", bus.Psel, bus.Penable, bus.Pwrite,
                     bus.rd_wr_en, bus.busy, bus.err_pulse, bus.timeout_pulse);
        end
        checks++;
        if ({bus.Paddr, bus.Pdata, bus.rd_wdata, bus.xfer_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h %h want 0", bus.Paddr, bus.Pdata, bus.rd_wdata, bus.xfer_cnt);
        end
    endtask

    task automatic test_zero_wait_write();
        rst = 1'b0; waits = 0;
        clear_log();
        repeat (5) cycle();
        checks++; if (n_pop !== 1 || first_pop !== 0) begin errors++; $display("FAIL zw_pop got n=%0d at %0d want n=1 at 0", n_pop, first_pop); end
        checks++; if (n_psel !== 2 || first_psel !== 1) begin errors++; $display("FAIL zw_psel got n=%0d at %0d want n=2 at 1", n_psel, first_psel); end
        checks++; if (n_pen !== 1 || first_pen !== 2) begin errors++; $display("FAIL zw_penable got n=%0d at %0d want n=1 at 2", n_pen, first_pen); end
        checks++; if (cap_addr !== 32'h10 || cap_data !== 32'hA5A5_A5A5 || cap_write !== 1'b1) begin
            errors++; $display("FAIL zw_bus got %h %h %b want 00000010 a5a5a5a5 1", cap_addr, cap_data, cap_write); end
        checks++; if (n_push !== 0) begin errors++; $display("FAIL zw_no_push got %0d want 0", n_push); end
        checks++; if (bus.xfer_cnt !== 16'd1) begin errors++; $display("FAIL zw_xfer_cnt got %0d want 1", bus.xfer_cnt); end
    endtask

    task automatic test_read_wait();
        waits = 2; prdata_cfg = 32'h1234_5678;
        push_cmd(32'h20, 32'h0, 1'b0);
        clear_log();
        repeat (8) cycle();
        checks++; if (n_push !== 1 || push_data !== 32'h1234_5678) begin
            errors++; $display("FAIL rw_push got n=%0d d=%h want n=1 d=12345678", n_push, push_data); end
        checks++; if (last_pen - first_pop + 1 !== 5) begin errors++; $display("FAIL rw_length got %0d want 5", last_pen - first_pop + 1); end
        checks++; if (push_cyc !== last_pen) begin errors++; $display("FAIL rw_push_cycle got %0d want %0d", push_cyc, last_pen); end
        checks++; if (cap_write !== 1'b0 || cap_addr !== 32'h20) begin errors++; $display("FAIL rw_bus got %h %b want 00000020 0", cap_addr, cap_write); end
        checks++; if (bus.xfer_cnt !== 16'd2) begin errors++; $display("FAIL rw_xfer_cnt got %0d want 2", bus.xfer_cnt); end
    endtask

    task automatic test_rd_full();
        waits = 0; prdata_cfg = 32'hCAFE_0001;
        bus.rd_full = 1'b1;
        push_cmd(32'h30, 32'h0, 1'b0);
        clear_log();
        repeat (4) cycle();
        checks++; if (n_pop !== 0 || n_psel !== 0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL rf_stall got pop=%0d psel=%0d busy=%b want 0 0 0", n_pop, n_psel, bus.busy); end
        bus.rd_full = 1'b0;
        repeat (5) cycle();
        checks++; if (first_pop !== 4 || first_psel !== 5) begin
            errors++; $display("FAIL rf_release got pop@%0d setup@%0d want 4 5", first_pop, first_psel); end
        checks++; if (n_push !== 1 || push_data !== 32'hCAFE_0001) begin
            errors++; $display("FAIL rf_push got n=%0d d=%h want 1 cafe0001", n_push, push_data); end
        bus.rd_full = 1'b1;
        push_cmd(32'h40, 32'hDEAD_BEEF, 1'b1);
        clear_log();
        repeat (4) cycle();
        checks++; if (first_pop !== 0 || n_psel !== 2 || n_push !== 0) begin
            errors++; $display("FAIL rf_write_passes got pop@%0d psel=%0d push=%0d want 0 2 0", first_pop, n_psel, n_push); end
        checks++; if (bus.xfer_cnt !== 16'd4) begin errors++; $display("FAIL rf_xfer_cnt got %0d want 4", bus.xfer_cnt); end
        bus.rd_full = 1'b0;
    endtask

    task automatic test_timeout();
        waits = -1; prdata_cfg = 32'hFFFF_FFFF;
        push_cmd(32'h50, 32'h0, 1'b0);
        push_cmd(32'h60, 32'h1, 1'b1);
        clear_log();
        repeat (7) cycle();
        waits = 0;
        repeat (5) cycle();
        checks++; if (n_push !== 1 || push_data !== 32'h0 || push_cyc !== 5) begin
            errors++; $display("FAIL to_push got n=%0d d=%h @%0d want 1 0 @5", n_push, push_data, push_cyc); end
        checks++; if (n_to !== 1 || to_cyc !== 6) begin errors++; $display("FAIL to_pulse got n=%0d @%0d want 1 @6", n_to, to_cyc); end
        checks++; if (n_err !== 1 || err_cyc !== 6) begin errors++; $display("FAIL to_err got n=%0d @%0d want 1 @6", n_err, err_cyc); end
        checks++; if (n_pop !== 2 || pop_cyc[1] !== 6) begin errors++; $display("FAIL to_next got n=%0d @%0d want 2 @6", n_pop, pop_cyc[1]); end
        checks++; if (n_pen !== 5 || n_psel !== 7) begin errors++; $display("FAIL to_phases got pen=%0d psel=%0d want 5 7", n_pen, n_psel); end
        checks++; if (bus.xfer_cnt !== 16'd6) begin errors++; $display("FAIL to_xfer_cnt got %0d want 6", bus.xfer_cnt); end
    endtask

    task automatic test_back_to_back();
        waits = 0; slverr_cfg = 1'b1;
        push_cmd(32'h70, 32'h7, 1'b1);
        clear_log();
        repeat (5) cycle();
        checks++; if (n_err !== 1 || err_cyc !== 3) begin errors++; $display("FAIL se_err got n=%0d @%0d want 1 @3", n_err, err_cyc); end
        checks++; if (n_to !== 0) begin errors++; $display("FAIL se_no_timeout got %0d want 0", n_to); end
        slverr_cfg = 1'b0;
        push_cmd(32'h74, 32'h1, 1'b1);
        push_cmd(32'h78, 32'h2, 1'b1);
        push_cmd(32'h7C, 32'h3, 1'b1);
        clear_log();
        repeat (11) cycle();
        checks++; if (n_pop !== 3 || pop_cyc[0] !== 0 || pop_cyc[1] !== 3 || pop_cyc[2] !== 6) begin
            errors++; $display("FAIL b2b_spacing got n=%0d @%0d,%0d,%0d want 3 @0,3,6", n_pop, pop_cyc[0], pop_cyc[1], pop_cyc[2]); end
        checks++; if (n_err !== 0 || cap_addr !== 32'h7C || cap_data !== 32'h3) begin
            errors++; $display("FAIL b2b_last got err=%0d %h %h want 0 0000007c 00000003", n_err, cap_addr, cap_data); end
        checks++; if (bus.xfer_cnt !== 16'd10) begin errors++; $display("FAIL b2b_xfer_cnt got %0d want 10", bus.xfer_cnt); end
    endtask

    task automatic test_reset_mid();
        waits = -1; prdata_cfg = 32'h5555_AAAA;
        push_cmd(32'h80, 32'h0, 1'b0);
        clear_log();
        repeat (4) cycle();
        checks++; if (bus.busy !== 1'b1 || bus.Penable !== 1'b1) begin
            errors++; $display("FAIL rm_in_access got busy=%b pen=%b want 1 1", bus.busy, bus.Penable); end
        rst = 1'b1; waits = 0;
        cycle();
        checks++; if (bus.Psel !== 1'b0 || bus.Penable !== 1'b0 || bus.Paddr !== 32'h0) begin
            errors++; $display("FAIL rm_drop got psel=%b pen=%b addr=%h want 0 0 0", bus.Psel, bus.Penable, bus.Paddr); end
        checks++; if (n_push !== 0) begin errors++; $display("FAIL rm_no_push got %0d want 0", n_push); end
        checks++; if (bus.xfer_cnt !== 16'd0) begin errors++; $display("FAIL rm_xfer_cnt got %0d want 0", bus.xfer_cnt); end
        rst = 1'b0;
        push_cmd(32'h90, 32'h9, 1'b1);
        clear_log();
        repeat (5) cycle();
        checks++; if (n_pop !== 1 || n_pen !== 1 || cap_addr !== 32'h90) begin
            errors++; $display("FAIL rm_restart got pop=%0d pen=%0d addr=%h want 1 1 00000090", n_pop, n_pen, cap_addr); end
        checks++; if (bus.xfer_cnt !== 16'd1) begin errors++; $display("FAIL rm_restart_cnt got %0d want 1", bus.xfer_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        waits = 0; acc_n = 0; slverr_cfg = 1'b0; prdata_cfg = '0;
        bus.rd_full = 1'b0; bus.Pready = 1'b0; bus.Pslverr = 1'b0; bus.Prdata = '0;
        drive_head();
        @(negedge clk); #1;
        test_reset();
        test_zero_wait_write();
        test_read_wait();
        test_rd_full();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
- Sequences the APB side of the AHB-to-APB bridge.
- Pops commands (addr, wdata, write) from the bridge's command FIFO and drives the APB SETUP/ACCESS phases.
- Waits on Pready, with an optional timeout.
- Pushes read data into the read-data FIFO, honouring the FIFO empty/full flags so neither FIFO overflows or underflows.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 16, max ACCESS cycles without Pready before abort; 0 disables timeout
CW, 16, width of transfer counter

Ports:
Pclk  in  1  clock, all logic on rising edge
Preset  in  1  synchronous active-high reset
cmd_empty  in  1  command FIFO empty (first-word-fall-through)
cmd_addr  in  AW  head command address, valid when !cmd_empty
cmd_wdata  in  DW  head command write data
cmd_write  in  1  head command direction, 1=write
cmd_rd_en  out  1  pop command FIFO
rd_full  in  1  read-data FIFO full
rd_wr_en  out  1  push read-data FIFO
rd_wdata  out  DW  read data pushed
Psel  out  1  APB select
Penable  out  1  APB enable
Pwrite  out  1  APB direction
Paddr  out  AW  APB address
Pdata  out  DW  APB write data
Prdata  in  DW  APB read data
Pready  in  1  APB ready
Pslverr  in  1  APB slave error
busy  out  1  state != IDLE
err_pulse  out  1  one-cycle pulse: slave error or timeout on completed/aborted transfer
timeout_pulse  out  1  one-cycle pulse: transfer aborted by timeout
xfer_cnt  out  CW  count of completed or aborted transfers, wraps

Behaviour:
- Reset (Preset=1 at an edge):
  - State goes to IDLE.
  - Psel, Penable, Pwrite, cmd_rd_en, rd_wr_en, busy, err_pulse and timeout_pulse are 0.
  - Paddr, Pdata, rd_wdata and xfer_cnt are 0.
  - Reset mid-transfer: Psel/Penable drop at that edge. No push occurs. The popped command is discarded.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - Start condition: !cmd_empty && (cmd_write || !rd_full).
  - On start, cmd_rd_en=1 combinationally in that cycle, and cmd_addr/cmd_wdata/cmd_write are registered into Paddr/Pdata/Pwrite.
  - Next state on start is SETUP; otherwise stay in IDLE.
  - A read command with rd_full=1 stalls in IDLE without popping. Checking rd_full here reserves FIFO space for the read result.
- SETUP: Psel=1, Penable=0 for exactly one cycle; always moves to ACCESS.
- ACCESS:
  - Psel=1, Penable=1. Paddr, Pwrite and Pdata are held stable for the whole transfer.
  - Completion cycle is any ACCESS cycle with Pready=1.
  - Read completion: rd_wr_en=1 and rd_wdata=Prdata combinationally in the completion cycle.
  - Completion or slave error: err_pulse is registered (asserted the cycle after completion) when Pslverr=1; xfer_cnt increments; next state is IDLE.
- Timeout:
  - A wait counter clears on SETUP→ACCESS and increments each ACCESS cycle with Pready=0.
  - If TIMEOUT>0 and the counter reaches TIMEOUT-1 with Pready=0, the transfer aborts.
  - Abort in a read: push rd_wdata=0 in that cycle, so responses stay 1:1 with read commands.
  - Next cycle after abort: timeout_pulse=1 and err_pulse=1; xfer_cnt increments; state returns to IDLE with Psel=Penable=0.
- Timing:
  - Minimum transfer is 3 cycles (IDLE pop, SETUP, ACCESS). Back-to-back transfers therefore issue every 3 cycles.
  - Each Pready=0 cycle in ACCESS adds one cycle.
- Outputs:
  - Psel, Penable, Paddr, Pwrite and Pdata are registered.
  - cmd_rd_en and rd_wr_en/rd_wdata are combinational from state and inputs.
  - cmd_rd_en is never asserted when cmd_empty=1; rd_wr_en is never asserted for a write.
- Other rules:
  - Pslverr is sampled only in the completion cycle.
  - xfer_cnt wraps from 2^CW-1 to 0.

Test Plan:
- Zero-wait write: cmd {0x10, 0xA5A5A5A5, write} → cmd_rd_en 1 cycle; Psel high 2 cycles; Penable in cycle 3 only; Paddr=0x10, Pdata=0xA5A5A5A5; no rd_wr_en; xfer_cnt=1.
- Read with 2 wait states: Pready low 2 ACCESS cycles, Prdata=0x12345678 → rd_wr_en single pulse with rd_wdata=0x12345678; transfer length 5 cycles.
- Read blocked by rd_full=1 for 4 cycles → no pop, Psel=0; SETUP begins the cycle after rd_full drops. A write queued with rd_full=1 proceeds immediately.
- Timeout, TIMEOUT=4, Pready stuck 0 on a read → abort after 4 ACCESS cycles; rd_wdata=0 pushed; timeout_pulse and err_pulse each 1 cycle; next command proceeds.
- Slave error: Pslverr=1 with Pready → err_pulse 1 cycle, timeout_pulse 0; three queued writes issue at 3-cycle spacing.
- Reset asserted in ACCESS of a read → Psel/Penable 0 at next edge; no rd_wr_en; xfer_cnt=0; next command starts normally.
